// File: rtl/mem_pkg.sv
// Shared types for the memory responder and its arbiter.
//   state_e : responder FSM states
//   op_e    : request kind (read or write)
//   req_t   : latched request (op, address, write data)
//   idx_bits: width needed to hold an index 0..n-1 (at least 1 bit)
package mem_pkg;

  localparam int REQ_ADDR_BITS = 8;
  localparam int REQ_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    op_e                      op;
    logic [REQ_ADDR_BITS-1:0] addr;
    logic [REQ_DATA_BITS-1:0] data;
  } req_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : N-wide request vector
//   last_grant : index granted most recently; search starts just after it
//   grant      : one-hot grant (all zero when nothing requests)
//   idx        : index of the granted requester
//   valid      : some requester was granted
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N  = 1,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand_s;

  // walk the channels from last_grant+1 (wrapping) and take the first requester
  always_comb begin
    grant  = {N{1'b0}};
    idx    = {IW{1'b0}};
    valid  = 1'b0;
    cand_s = {IW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      cand_s = IW'((int'(last_grant) + i) % N);
      if (!valid && req[cand_s]) begin
        valid         = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-channel valid/ready memory protocol.
// Channels are arbitrated round-robin onto one single-ported storage array;
// each granted request completes LATENCY cycles after its grant and ready
// is held until the requester drops valid.
//   clk, reset        : clock, asynchronous active-low reset
//   read_valid/address: per-channel read request
//   read_ready/data   : per-channel read completion and data (0 when idle)
//   write_valid/address/data: per-channel write request
//   write_ready       : per-channel write completion
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = REQ_ADDR_BITS,
  parameter int DATA_BITS = REQ_DATA_BITS,
  parameter int CHANNELS  = 1,
  parameter int LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [CHANNELS-1:0]           read_ready,
  output logic [CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [CHANNELS-1:0]           write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [CHANNELS*DATA_BITS-1:0] write_data,
  output logic [CHANNELS-1:0]           write_ready
);

  localparam int IW = idx_bits(CHANNELS);
  localparam int CW = idx_bits(LATENCY);   // counter holds LATENCY-1

  state_e                        state_r;
  req_t                          req_r;
  logic [IW-1:0]                 ch_r;
  logic [IW-1:0]                 last_grant_r;
  logic [CW-1:0]                 cnt_r;
  logic [CHANNELS-1:0]           read_ready_r;
  logic [CHANNELS-1:0]           write_ready_r;
  logic [CHANNELS*DATA_BITS-1:0] read_data_r;
  logic [DATA_BITS-1:0]          mem_r [2**ADDR_BITS];

  logic [CHANNELS-1:0] any_req_s;
  logic [CHANNELS-1:0] arb_grant_s;
  logic [IW-1:0]       arb_idx_s;
  logic                arb_valid_s;
  logic                grant_write_s;
  logic                granted_valid_s;
  logic                commit_s;

  assign any_req_s = read_valid | write_valid;

  rr_arbiter #(
    .N  (CHANNELS),
    .IW (IW)
  ) u_arb (
    .req        (any_req_s),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .idx        (arb_idx_s),
    .valid      (arb_valid_s)
  );

  // a channel asking for both is served as a write; its read stays pending
  assign grant_write_s   = |(arb_grant_s & write_valid);
  assign granted_valid_s = (req_r.op == OP_WRITE) ? write_valid[ch_r] : read_valid[ch_r];
  // the write lands on the same edge its ready rises, so a later read sees it
  assign commit_s = (state_r == BUSY) && (cnt_r == {CW{1'b0}}) && (req_r.op == OP_WRITE);

  // request FSM: grant, latency countdown, then hold ready until valid drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      req_r         <= '0;
      ch_r          <= {IW{1'b0}};
      last_grant_r  <= {IW{1'b0}};
      cnt_r         <= {CW{1'b0}};
      read_ready_r  <= {CHANNELS{1'b0}};
      write_ready_r <= {CHANNELS{1'b0}};
      read_data_r   <= {(CHANNELS*DATA_BITS){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            ch_r     <= arb_idx_s;
            req_r.op <= grant_write_s ? OP_WRITE : OP_READ;
            req_r.addr <= grant_write_s ? write_address[arb_idx_s*ADDR_BITS +: ADDR_BITS]
                                        : read_address[arb_idx_s*ADDR_BITS +: ADDR_BITS];
            req_r.data <= grant_write_s ? write_data[arb_idx_s*DATA_BITS +: DATA_BITS]
                                        : {DATA_BITS{1'b0}};
            cnt_r    <= CW'(LATENCY - 1);
            state_r  <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            if (req_r.op == OP_WRITE) begin
              write_ready_r[ch_r] <= 1'b1;
            end else begin
              read_ready_r[ch_r] <= 1'b1;
              read_data_r[ch_r*DATA_BITS +: DATA_BITS] <= mem_r[req_r.addr];
            end
            state_r <= RESPOND;
          end
        end
        RESPOND: begin
          // also covers a requester that dropped valid early: ready lasts one cycle
          if (!granted_valid_s) begin
            read_ready_r  <= {CHANNELS{1'b0}};
            write_ready_r <= {CHANNELS{1'b0}};
            read_data_r   <= {(CHANNELS*DATA_BITS){1'b0}};
            last_grant_r  <= ch_r;
            state_r       <= IDLE;
          end else begin
            state_r <= RESPOND;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // storage write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[req_r.addr] <= req_r.data;
    end
  end

  assign read_ready  = read_ready_r;
  assign write_ready = write_ready_r;
  assign read_data   = read_data_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Four instances:
//   0: CHANNELS=1 LATENCY=2   1: CHANNELS=4 LATENCY=2
//   2: CHANNELS=1 LATENCY=1   3: CHANNELS=1 LATENCY=5
// Expected completions are queued before stimulus; a monitor pops one on
// every rising ready and checks instance, channel, op and read data.
module tb_mem_responder;

  typedef struct {
    int         inst;
    int         ch;
    bit         w;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        rst_n;
  logic [3:0][3:0]   rv, wv, rr_a, wr_a;
  logic [3:0][31:0]  ra, wa, wd, rd_a;
  logic [3:0][3:0]   prev_act = '0;
  logic [3:0][3:0]   prev_rr  = '0;
  exp_t              sb_q[$];
  exp_t              mon_e;
  int                n_tests = 0;
  int                n_fail  = 0;

  genvar g;
  for (g = 0; g < 4; g++) begin : gi
    localparam int CH  = (g == 1) ? 4 : 1;
    localparam int LAT = (g == 2) ? 1 : ((g == 3) ? 5 : 2);
    logic [CH-1:0]   rr_l, wr_l;
    logic [CH*8-1:0] rd_l;
    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(CH), .LATENCY(LAT)) u_dut (
      .clk           (clk),
      .reset         (rst_n[g]),
      .read_valid    (rv[g][CH-1:0]),
      .read_address  (ra[g][CH*8-1:0]),
      .read_ready    (rr_l),
      .read_data     (rd_l),
      .write_valid   (wv[g][CH-1:0]),
      .write_address (wa[g][CH*8-1:0]),
      .write_data    (wd[g][CH*8-1:0]),
      .write_ready   (wr_l)
    );
    assign rr_a[g] = 4'(rr_l);
    assign wr_a[g] = 4'(wr_l);
    assign rd_a[g] = 32'(rd_l);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_rsp(input int gi_n, input int ch, input bit w, input logic [7:0] d);
    exp_t e;
    e.inst = gi_n; e.ch = ch; e.w = w; e.data = d;
    sb_q.push_back(e);
  endtask

  // one requester transaction; lat >= 0 checks grant-to-ready delay (DUT idle at start)
  task automatic req(input int gi_n, input int ch, input bit w, input logic [7:0] a,
                     input logic [7:0] d, input int lat);
    int n;
    bit seen;
    @(posedge clk); #1;
    if (w) begin
      wa[gi_n][ch*8 +: 8] = a; wd[gi_n][ch*8 +: 8] = d; wv[gi_n][ch] = 1'b1;
    end else begin
      ra[gi_n][ch*8 +: 8] = a; rv[gi_n][ch] = 1'b1;
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = w ? wr_a[gi_n][ch] : rr_a[gi_n][ch];
    end
    if (!seen) check("ready_timeout", 32'(seen), 32'd1);
    else if (lat >= 0) check(w ? "wr_latency" : "rd_latency", 32'(n - 2), 32'(lat));
    @(posedge clk); #1;
    if (w) wv[gi_n][ch] = 1'b0;
    else   rv[gi_n][ch] = 1'b0;
  endtask

  // scoreboard monitor: rising ready pops an expectation; falling read_ready clears data
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if ((rr_a[m] | wr_a[m]) != 4'd0) check("one_ready", $countones(rr_a[m] | wr_a[m]), 32'd1);
      for (int c = 0; c < 4; c++) begin
        if ((rr_a[m][c] | wr_a[m][c]) && !prev_act[m][c]) begin
          if (sb_q.size() == 0) begin
            check("unexpected_ready", 32'(rr_a[m] | wr_a[m]), 32'd0);
          end else begin
            mon_e = sb_q.pop_front();
            check("sb_inst", 32'(m), 32'(mon_e.inst));
            check("sb_ch", 32'(c), 32'(mon_e.ch));
            check("sb_op", 32'(wr_a[m][c]), 32'(mon_e.w));
            if (!mon_e.w) check("rdata", 32'(rd_a[m][c*8 +: 8]), 32'(mon_e.data));
          end
        end
        if (prev_rr[m][c] && !rr_a[m][c]) check("rd_clear", 32'(rd_a[m][c*8 +: 8]), 32'd0);
      end
      prev_act[m] <= rr_a[m] | wr_a[m];
      prev_rr[m]  <= rr_a[m];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    rst_n = 4'hF;
    #1 rst_n = 4'h0;
    #20;
    for (int i = 0; i < 4; i++) begin
      check("rst_rr", 32'(rr_a[i]), 32'd0);
      check("rst_wr", 32'(wr_a[i]), 32'd0);
      check("rst_rd", rd_a[i], 32'd0);
    end
    @(negedge clk); rst_n = 4'hF;

    // single write then read, CHANNELS=1 LATENCY=2
    expect_rsp(0, 0, 1'b1, 8'h00); req(0, 0, 1'b1, 8'h10, 8'h5A, 2);
    expect_rsp(0, 0, 1'b0, 8'h5A); req(0, 0, 1'b0, 8'h10, 8'h00, 2);

    // round robin: preload, then all four read together
    for (int k = 0; k < 4; k++) begin
      expect_rsp(1, k, 1'b1, 8'h00); req(1, k, 1'b1, 8'(k), 8'(8'hA0 + k), 2);
    end
    for (int k = 0; k < 4; k++) expect_rsp(1, k, 1'b0, 8'(8'hA0 + k));
    fork
      req(1, 0, 1'b0, 8'h00, 8'h00, -1);
      req(1, 1, 1'b0, 8'h01, 8'h00, -1);
      req(1, 2, 1'b0, 8'h02, 8'h00, -1);
      req(1, 3, 1'b0, 8'h03, 8'h00, -1);
    join

    // fairness: ch0 re-requests at once, ch2 waiting must go first
    expect_rsp(1, 0, 1'b0, 8'hA0);
    expect_rsp(1, 2, 1'b0, 8'hA2);
    expect_rsp(1, 0, 1'b0, 8'hA1);
    fork
      begin
        req(1, 0, 1'b0, 8'h00, 8'h00, -1);
        req(1, 0, 1'b0, 8'h01, 8'h00, -1);
      end
      req(1, 2, 1'b0, 8'h02, 8'h00, -1);
    join

    // simultaneous read+write on one channel: write first, read sees new data
    expect_rsp(1, 0, 1'b1, 8'h00); req(1, 0, 1'b1, 8'h20, 8'h11, 2);
    expect_rsp(1, 0, 1'b1, 8'h00);
    expect_rsp(1, 0, 1'b0, 8'h22);
    fork
      req(1, 0, 1'b1, 8'h20, 8'h22, -1);
      req(1, 0, 1'b0, 8'h20, 8'h00, -1);
    join

    // reset in BUSY: write must not commit
    expect_rsp(0, 0, 1'b1, 8'h00); req(0, 0, 1'b1, 8'h30, 8'h33, 2);
    @(posedge clk); #1;
    wa[0][7:0] = 8'h30; wd[0][7:0] = 8'h77; wv[0][0] = 1'b1;
    @(posedge clk);
    @(negedge clk); #2;
    rst_n[0] = 1'b0; #1;
    check("busy_rst_wr", 32'(wr_a[0]), 32'd0);
    check("busy_rst_rr", 32'(rr_a[0]), 32'd0);
    repeat (2) @(negedge clk);
    wv[0][0] = 1'b0;
    @(negedge clk); rst_n[0] = 1'b1;
    expect_rsp(0, 0, 1'b0, 8'h33); req(0, 0, 1'b0, 8'h30, 8'h00, 2);

    // reset in RESPOND: ready and data clear without a clock edge
    expect_rsp(0, 0, 1'b0, 8'h33);
    @(posedge clk); #1;
    ra[0][7:0] = 8'h30; rv[0][0] = 1'b1;
    n = 0;
    while (!rr_a[0][0] && n < 100) begin @(negedge clk); n++; end
    check("resp_seen", 32'(rr_a[0][0]), 32'd1);
    #2 rst_n[0] = 1'b0; #1;
    check("resp_rst_rr", 32'(rr_a[0]), 32'd0);
    check("resp_rst_rd", rd_a[0], 32'd0);
    @(negedge clk); rv[0][0] = 1'b0;
    @(negedge clk); rst_n[0] = 1'b1;

    // latency sweep
    expect_rsp(2, 0, 1'b1, 8'h00); req(2, 0, 1'b1, 8'h40, 8'h9C, 1);
    expect_rsp(2, 0, 1'b0, 8'h9C); req(2, 0, 1'b0, 8'h40, 8'h00, 1);
    expect_rsp(3, 0, 1'b1, 8'h00); req(3, 0, 1'b1, 8'h40, 8'hC9, 5);
    expect_rsp(3, 0, 1'b0, 8'hC9); req(3, 0, 1'b0, 8'h40, 8'h00, 5);

    // valid dropped during BUSY: write still commits, ready lasts one cycle
    expect_rsp(3, 0, 1'b1, 8'h00);
    @(posedge clk); #1;
    wa[3][7:0] = 8'h50; wd[3][7:0] = 8'h44; wv[3][0] = 1'b1;
    @(posedge clk);
    @(negedge clk); wv[3][0] = 1'b0;
    n = 0;
    while (!wr_a[3][0] && n < 100) begin @(negedge clk); n++; end
    check("viol_seen", 32'(wr_a[3][0]), 32'd1);
    @(negedge clk);
    check("viol_one_cycle", 32'(wr_a[3][0]), 32'd0);
    expect_rsp(3, 0, 1'b0, 8'h44); req(3, 0, 1'b0, 8'h50, 8'h00, 5);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
